// File: rtl/clk_test_stage.sv
// One delay-line register with synchronous reset. The reset value is a parameter
// so the block shows a known pattern once reset has reached the flops.
module clk_test_stage #(
  parameter int unsigned           WIDTH       = 16,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VALUE;
    else     q <= d;
  end

endmodule

// File: rtl/clk_test.sv
// Clock/reset bring-up probe: a registered delay line of LATENCY stages from data_in to data_out.
// It gives a fixed latency, and it shows RESET_VALUE on data_out after a reset edge.
module clk_test #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      LATENCY     = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  generate
    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
      $error("clk_test: LATENCY must be in 1..16");
    end
  endgenerate

  logic [LATENCY-1:0][WIDTH-1:0] stage;

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    logic [WIDTH-1:0] d;
    if (g == 0) begin : g_head
      assign d = data_in;
    end else begin : g_body
      assign d = stage[g-1];
    end

    clk_test_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (stage[g])
    );
  end

  // The output comes straight from the last flop, with no logic after it.
  assign data_out = stage[LATENCY-1];

endmodule

// File: tb/tb_clk_test.sv
// Directed bench for clk_test: default build, a LATENCY=4 build, a non-zero RESET_VALUE build,
// and an instance on a separately controlled clock so reset can be asserted while that clock is stopped.
module tb_clk_test;

  logic        clk = 1'b0;
  logic        clkx = 1'b0;
  logic        rst0, rst1, rst2, rst3;
  logic [15:0] din0, din1, din2, din3;
  logic [15:0] dout0, dout1, dout2, dout3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_test u_dut0 (.clk(clk), .rst(rst0), .data_in(din0), .data_out(dout0));

  clk_test #(.LATENCY(4)) u_dut1 (.clk(clk), .rst(rst1), .data_in(din1), .data_out(dout1));

  clk_test #(.RESET_VALUE(16'hA5A5)) u_dut2 (.clk(clk), .rst(rst2), .data_in(din2), .data_out(dout2));

  clk_test #(.RESET_VALUE(16'h5A5A)) u_dut3 (.clk(clkx), .rst(rst3), .data_in(din3), .data_out(dout3));

  // Inputs change 1 ns after the edge, and outputs are sampled at that same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; din0 = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout0 !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected 0000", i, dout0);
      end
    end
  endtask

  task automatic test_latency1();
    rst0 = 1'b0; din0 = 16'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout0 !== 16'd1) begin
        errors++;
        $display("FAIL lat1_one[%0d]: got %h expected 0001", i, dout0);
      end
    end
    din0 = 16'd12;
    tick();
    checks++;
    if (dout0 !== 16'd12) begin
      errors++;
      $display("FAIL lat1_twelve: got %h expected 000c", dout0);
    end
  endtask

  task automatic test_collision();
    // Assert reset and change data_in in the same cycle. Reset wins, and the new word is not captured.
    rst0 = 1'b1; din0 = 16'd3;
    tick();
    checks++;
    if (dout0 !== 16'h0000) begin
      errors++;
      $display("FAIL collision_reset: got %h expected 0000", dout0);
    end
    rst0 = 1'b0;
    tick();
    checks++;
    if (dout0 !== 16'd3) begin
      errors++;
      $display("FAIL collision_after: got %h expected 0003", dout0);
    end
  endtask

  task automatic test_midcycle();
    din0 = 16'd7;
    #3 din0 = 16'd9;
    #1 din0 = 16'd7;
    tick();
    checks++;
    if (dout0 !== 16'd7) begin
      errors++;
      $display("FAIL midcycle: got %h expected 0007", dout0);
    end
  endtask

  task automatic test_latency4_stream();
    logic [15:0] exp;
    rst1 = 1'b1; din1 = 16'hDEAD;
    for (int i = 0; i < 4; i++) tick();
    rst1 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din1 = 16'(i);
      tick();
      exp = (i < 3) ? 16'h0000 : 16'(i - 3);
      checks++;
      if (dout1 !== exp) begin
        errors++;
        $display("FAIL lat4_seq[%0d]: got %h expected %h", i, dout1, exp);
      end
    end
  endtask

  task automatic test_latency4_flush();
    logic [15:0] exp;
    for (int k = 0; k < 4; k++) begin
      din1 = 16'(100 + k);
      tick();
    end
    rst1 = 1'b1; din1 = 16'd200;
    tick();
    checks++;
    if (dout1 !== 16'h0000) begin
      errors++;
      $display("FAIL flush_reset_edge: got %h expected 0000", dout1);
    end
    rst1 = 1'b0;
    for (int j = 0; j < 7; j++) begin
      din1 = 16'(300 + j);
      tick();
      exp = (j < 3) ? 16'h0000 : 16'(300 + j - 3);
      checks++;
      if (dout1 !== exp) begin
        errors++;
        $display("FAIL flush_post[%0d]: got %h expected %h", j, dout1, exp);
      end
    end
  endtask

  task automatic test_reset_value();
    rst2 = 1'b1; din2 = 16'h1234;
    tick();
    checks++;
    if (dout2 !== 16'hA5A5) begin
      errors++;
      $display("FAIL rv_reset: got %h expected a5a5", dout2);
    end
    rst2 = 1'b0; din2 = 16'h8001;
    tick();
    checks++;
    if (dout2 !== 16'h8001) begin
      errors++;
      $display("FAIL rv_pass: got %h expected 8001", dout2);
    end
  endtask

  task automatic test_stopped_clock();
    // Assert rst while the clock is stopped. Release it before any edge, so no reset should occur.
    clkx = 1'b0; rst3 = 1'b1; din3 = 16'h0000;
    #50;
    rst3 = 1'b0;
    #5 clkx = 1'b1;
    #1;
    checks++;
    if (dout3 !== 16'h0000) begin
      errors++;
      $display("FAIL stopped_clk_capture: got %h expected 0000", dout3);
    end
    #4 clkx = 1'b0;
    din3 = 16'h0042;
    #5 clkx = 1'b1;
    #1;
    checks++;
    if (dout3 !== 16'h0042) begin
      errors++;
      $display("FAIL stopped_clk_second: got %h expected 0042", dout3);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    #1;
    test_reset();
    test_latency1();
    test_collision();
    test_midcycle();
    test_latency4_stream();
    test_latency4_flush();
    test_reset_value();
    test_stopped_clock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_test.md
# clk_test

Clock/reset sanity block: a parameterised registered delay line from `data_in` to `data_out`. It sits at the edge of the CPU datapath as a bring-up probe. It proves that the clock toggles and that synchronous reset reaches the flops. It also gives a known, fixed input-to-output latency for bench and board checks.

## Interface
Parameters:
- `WIDTH`, 16, data width of `data_in`/`data_out`.
- `LATENCY`, 1, number of register stages between `data_in` and `data_out`; legal range 1..16; any other value is an elaboration error.
- `RESET_VALUE`, 16'h0000, value loaded into every stage by reset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset, sampled on rising `clk`.
- `data_in`  input  WIDTH  sample word, captured every rising edge.
- `data_out`  output  WIDTH  `data_in` delayed by LATENCY rising edges; driven directly from the last stage flop.

## Operation
- The block is a shift chain `stage[0..LATENCY-1]`.
- On each rising `clk` with `rst`=0:
  - `stage[0]` <= `data_in`.
  - `stage[i]` <= `stage[i-1]`.
- `data_out` = `stage[LATENCY-1]`.
- There is no enable or handshake. Every edge shifts.
- On a rising `clk` with `rst`=1, all stages load RESET_VALUE, and `data_in` is ignored on that edge.
- There is no arithmetic. Data passes bit-exact, with no width change.
- Before the first reset edge, stage contents are undefined. Simulation may show X, and no initial value is required.
- If `rst` rises without a rising `clk` edge (clock stopped or X), nothing changes. Reset acts only on an edge.

## Timing
- Reset:
  - `data_out` = RESET_VALUE after the first rising edge with `rst`=1.
  - It stays at RESET_VALUE while `rst` is held.
  - On the first edge with `rst`=0, `stage[0]` captures `data_in`.
  - `data_out` shows that word LATENCY edges after the last reset edge.
- Latency: a word present at `data_in` at rising edge n appears on `data_out` immediately after edge n+LATENCY-1. Latency is 1 cycle for the default.
- Throughput: one word per cycle. Back-to-back changes are preserved in order, with none dropped or merged.
- Reset mid-stream flushes all in-flight words. The words already in the chain never appear on `data_out`.
- `rst` and a `data_in` change in the same cycle: reset wins, and the changed word is not captured on that edge.
- `data_in` only needs to be stable around the rising edge. Mid-cycle changes are invisible.

## Structure
- No shared package is needed.
- WIDTH, LATENCY and RESET_VALUE are local parameters of this block. They may be overridden at instantiation.
- The natural sub-module is `clk_test_stage`: one WIDTH-bit flop with synchronous reset to RESET_VALUE. The top instantiates it LATENCY times in a generate loop.
- The LATENCY range check is a generate-time `$error` in the top.

## Test plan
- Clock running, `rst`=1 for 3 cycles with `data_in`=16'hFFFF -> `data_out`=0 after the first reset edge and holds 0 throughout.
- Release `rst`, then `data_in`=1 held 3 cycles, then `data_in`=12 -> `data_out` becomes 1, then 12, each exactly 1 edge after the matching change (default LATENCY).
- LATENCY=4: drive an incrementing sequence 0,1,2,… every cycle -> `data_out` shows the same sequence delayed exactly 4 edges, with no gaps.
- LATENCY=4: assert `rst` for 1 cycle mid-stream -> `data_out`=RESET_VALUE for 4 consecutive edges, then new post-reset words; no pre-reset word appears.
- Clock held X/stopped while `rst`=1, then clock starts with `rst`=0 and `data_in`=0 -> no reset occurs; `data_out`=0 after 1 edge (captured data, not reset).
- RESET_VALUE=16'hA5A5 -> `data_out`=16'hA5A5 after reset; `data_in`=16'h8001 passes bit-exact.
